// File: rtl/gpmc_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gpmc_master
// GPMC initiator for a 16-bit multiplexed address/data bus. Turns one host
// request at a time into an asynchronous GPMC cycle:
//   IDLE -> ADDR (adv_n low, AD = address) -> DATA (oe_n or we_n low, WAIT
//   stretching) -> HOLD (strobe released, cs_n held) -> TURN (bus released).
// All GPMC outputs are registered, so they change only on the rising edge.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      host handshake; req_ready is high only in IDLE
//   req_write/addr/wdata/be_n request fields, captured at acceptance
//   rsp_valid                one-clock completion pulse (first HOLD clock)
//   rsp_rdata                read data, updated only by a successful read
//   rsp_err                  with rsp_valid: cycle aborted by WAIT timeout
//   gpmc_ad_o/ad_oe/ad_i     AD bus output, drive enable, input
//   gpmc_cs_n/adv_n/oe_n/we_n/be_n  bus strobes
//   gpmc_wait                target wait, synchronised by two flops
// -----------------------------------------------------------------------------
module gpmc_master #(
    parameter int unsigned ADV_CYC  = 2,
    parameter int unsigned ACC_CYC  = 4,
    parameter int unsigned HOLD_CYC = 1,
    parameter int unsigned TIMEOUT  = 255,
    parameter bit          WAIT_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be_n,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] gpmc_ad_o,
    output logic        gpmc_ad_oe,
    input  logic [15:0] gpmc_ad_i,
    output logic        gpmc_cs_n,
    output logic        gpmc_adv_n,
    output logic        gpmc_oe_n,
    output logic        gpmc_we_n,
    output logic [1:0]  gpmc_be_n,
    input  logic        gpmc_wait
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_TURN
    } state_t;

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be_n;
    } req_t;

    typedef struct packed {
        logic        cs_n;
        logic        adv_n;
        logic        oe_n;
        logic        we_n;
        logic        ad_oe;
        logic [15:0] ad_o;
        logic [1:0]  be_n;
    } bus_t;

    // Counter reload values: a phase of N clocks counts N-1 down to 0.
    localparam logic [7:0] ADV_LOAD  = 8'(ADV_CYC - 1);
    localparam logic [7:0] ACC_LOAD  = 8'(ACC_CYC - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);
    localparam logic [8:0] TMO_LIM   = 9'(TIMEOUT);

    localparam bus_t BUS_IDLE = '{cs_n: 1'b1, adv_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                  ad_oe: 1'b0, ad_o: 16'h0000, be_n: 2'b11};

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    // One bit wider than the counter so TIMEOUT=255 can still be exceeded.
    logic [8:0]  ext_cnt, ext_next;
    req_t        req_q, req_next;
    bus_t        bus_q, bus_next;
    logic        wait_s1, wait_s2, wait_act;
    logic        accept, data_end, abort;

    // Bus levels for a given state; TURN and IDLE both park the bus.
    function automatic bus_t drive(input state_t st, input req_t r);
        bus_t b;
        b = BUS_IDLE;
        case (st)
            S_ADDR: begin
                b.cs_n  = 1'b0;
                b.adv_n = 1'b0;
                b.ad_oe = 1'b1;
                b.ad_o  = r.addr;
                b.be_n  = r.be_n;
            end
            S_DATA: begin
                b.cs_n = 1'b0;
                b.be_n = r.be_n;
                if (r.write) begin
                    b.we_n  = 1'b0;
                    b.ad_oe = 1'b1;
                    b.ad_o  = r.wdata;
                end else begin
                    // AD stays released while the target drives read data.
                    b.oe_n = 1'b0;
                end
            end
            S_HOLD: begin
                b.cs_n = 1'b0;
                b.be_n = r.be_n;
                if (r.write) begin
                    b.ad_oe = 1'b1;
                    b.ad_o  = r.wdata;
                end
            end
            default: b = BUS_IDLE;
        endcase
        return b;
    endfunction

    assign wait_act  = (wait_s2 == WAIT_POL);
    assign req_ready = (state == S_IDLE);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_next = state;
        cnt_next   = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
        ext_next   = ext_cnt;
        accept     = 1'b0;
        data_end   = 1'b0;
        abort      = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = S_ADDR;
                    cnt_next   = ADV_LOAD;
                end
            end
            S_ADDR: begin
                if (cnt == 8'd0) begin
                    state_next = S_DATA;
                    cnt_next   = ACC_LOAD;
                    ext_next   = 9'd0;
                end
            end
            S_DATA: begin
                // Past the minimum access time, WAIT stretches one clock at a time.
                if (cnt == 8'd0) begin
                    if (!wait_act) begin
                        data_end   = 1'b1;
                        state_next = S_HOLD;
                        cnt_next   = HOLD_LOAD;
                    end else if (ext_cnt > TMO_LIM) begin
                        data_end   = 1'b1;
                        abort      = 1'b1;
                        state_next = S_HOLD;
                        cnt_next   = HOLD_LOAD;
                    end else begin
                        ext_next = ext_cnt + 9'd1;
                    end
                end
            end
            S_HOLD: begin
                if (cnt == 8'd0) begin
                    state_next = S_TURN;
                end
            end
            S_TURN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        req_next = req_q;
        if (accept) begin
            req_next = '{write: req_write, addr: req_addr, wdata: req_wdata, be_n: req_be_n};
        end

        // Outputs are decoded from the next state and registered with it.
        bus_next = drive(state_next, req_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            ext_cnt   <= 9'd0;
            req_q     <= '0;
            bus_q     <= BUS_IDLE;
            wait_s1   <= ~WAIT_POL;
            wait_s2   <= ~WAIT_POL;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_next;
            cnt       <= cnt_next;
            ext_cnt   <= ext_next;
            req_q     <= req_next;
            bus_q     <= bus_next;
            wait_s1   <= gpmc_wait;
            wait_s2   <= wait_s1;
            rsp_valid <= data_end;
            rsp_err   <= abort;
            if (data_end && !abort && !req_q.write) begin
                rsp_rdata <= gpmc_ad_i;
            end
        end
    end

    assign gpmc_cs_n  = bus_q.cs_n;
    assign gpmc_adv_n = bus_q.adv_n;
    assign gpmc_oe_n  = bus_q.oe_n;
    assign gpmc_we_n  = bus_q.we_n;
    assign gpmc_ad_oe = bus_q.ad_oe;
    assign gpmc_ad_o  = bus_q.ad_o;
    assign gpmc_be_n  = bus_q.be_n;

endmodule

// File: tb/tb_gpmc_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_gpmc_master
// Drives gpmc_master with directed and random single-word transactions while
// a small behavioural target (word memory, access time = ACC clocks) answers
// on the bus. Every cycle of every transaction is compared against a timeline
// computed arithmetically from the request and the WAIT pattern.
// -----------------------------------------------------------------------------
module tb_gpmc_master;

    localparam int ADV = 2;
    localparam int ACC = 4;
    localparam int HLD = 1;
    localparam int TMO = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  req_be_n;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [15:0] gpmc_ad_o, gpmc_ad_i;
    logic        gpmc_ad_oe, gpmc_cs_n, gpmc_adv_n, gpmc_oe_n, gpmc_we_n, gpmc_wait;
    logic [1:0]  gpmc_be_n;

    gpmc_master #(
        .ADV_CYC (ADV),
        .ACC_CYC (ACC),
        .HOLD_CYC(HLD),
        .TIMEOUT (TMO),
        .WAIT_POL(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be_n  (req_be_n),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .gpmc_ad_o (gpmc_ad_o),
        .gpmc_ad_oe(gpmc_ad_oe),
        .gpmc_ad_i (gpmc_ad_i),
        .gpmc_cs_n (gpmc_cs_n),
        .gpmc_adv_n(gpmc_adv_n),
        .gpmc_oe_n (gpmc_oe_n),
        .gpmc_we_n (gpmc_we_n),
        .gpmc_be_n (gpmc_be_n),
        .gpmc_wait (gpmc_wait)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Target-side memory and the reference copy the bench expects it to hold.
    logic [15:0] tgt_mem [64];
    logic [15:0] ref_mem [64];
    logic [15:0] t_addr, t_wdata;
    logic [1:0]  t_be;
    bit          t_wr;
    int          t_oe_cnt;
    logic [15:0] exp_rd_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of target behaviour, evaluated mid-cycle from the visible bus.
    task automatic target_step();
        if (!gpmc_cs_n && !gpmc_adv_n) t_addr = gpmc_ad_o;
        if (!gpmc_cs_n && !gpmc_we_n) begin
            t_wdata = gpmc_ad_o;
            t_be    = gpmc_be_n;
            t_wr    = 1'b1;
        end
        if (gpmc_cs_n && t_wr) begin
            if (!t_be[0]) tgt_mem[t_addr[5:0]][7:0]  = t_wdata[7:0];
            if (!t_be[1]) tgt_mem[t_addr[5:0]][15:8] = t_wdata[15:8];
            t_wr = 1'b0;
        end
        // Read data becomes valid only after the full access time.
        if (!gpmc_oe_n && t_oe_cnt >= ACC - 1) gpmc_ad_i = tgt_mem[t_addr[5:0]];
        else                                  gpmc_ad_i = 16'($urandom);
        t_oe_cnt = gpmc_oe_n ? 0 : t_oe_cnt + 1;
    endtask

    // Called at the falling edge of an IDLE cycle; returns at the falling edge
    // of the IDLE cycle following TURN.
    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be, input int stall_at, input int stall_len,
                           input bit stuck);
        bit          w [64];
        int          len, rsp_k, hold_end, turn_k;
        bit          err, in_data, exp_adoe;
        logic [15:0] new_rd;
        logic [6:0]  exp_str;

        // w[k] is the WAIT level presented in clock k after acceptance.
        for (int k = 0; k < 64; k++)
            w[k] = (k > 0) && (stuck ? (k <= ADV + ACC + TMO + 2)
                                     : (k >= stall_at && k < stall_at + stall_len));

        // DATA clock j ends at edge ADV+j and sees WAIT as it was two clocks earlier.
        len = 0;
        err = 1'b0;
        for (int j = ACC; j < 60 && len == 0; j++) begin
            if (!w[ADV + j - 2]) len = j;
            else if (j - ACC > TMO) begin
                len = j;
                err = 1'b1;
            end
        end
        rsp_k    = ADV + len + 1;
        hold_end = ADV + len + HLD;
        turn_k   = hold_end + 1;
        new_rd   = (wr || err) ? exp_rd_hold : ref_mem[addr[5:0]];

        check("idle_ready", req_ready, 1);
        check("idle_strobes", {gpmc_cs_n, gpmc_adv_n, gpmc_oe_n, gpmc_we_n, gpmc_ad_oe, gpmc_be_n},
              7'b1111011);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be_n  = be;
        gpmc_wait = 1'b0;
        target_step();
        @(posedge clk);

        for (int k = 1; k <= turn_k; k++) begin
            @(negedge clk);
            in_data  = (k > ADV) && (k <= ADV + len);
            exp_adoe = (k <= ADV) || (wr && k <= hold_end);
            exp_str  = {k > hold_end, k > ADV, !(in_data && !wr), !(in_data && wr), exp_adoe,
                        (k <= hold_end) ? be : 2'b11};
            check("strobes", {gpmc_cs_n, gpmc_adv_n, gpmc_oe_n, gpmc_we_n, gpmc_ad_oe, gpmc_be_n},
                  exp_str);
            if (exp_adoe)
                check((k <= ADV) ? "ad_addr" : "ad_wdata", gpmc_ad_o, (k <= ADV) ? addr : wdata);
            check("ready_busy", req_ready, 0);
            check("rsp_valid", rsp_valid, k == rsp_k);
            if (k == rsp_k) check("rsp_err", rsp_err, err);
            check("rsp_rdata", rsp_rdata, (k >= rsp_k) ? new_rd : exp_rd_hold);
            // Fields change after acceptance and a held req_valid must be ignored.
            req_write = 1'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            req_be_n  = 2'($urandom);
            gpmc_wait = w[k];
            target_step();
        end
        @(negedge clk);

        // The target saw the write strobe even on an aborted cycle.
        if (wr) begin
            if (!be[0]) ref_mem[addr[5:0]][7:0]  = wdata[7:0];
            if (!be[1]) ref_mem[addr[5:0]][15:8] = wdata[15:8];
        end
        exp_rd_hold = new_rd;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int gap;
        bit wr, stuck;
        int s_at, s_len;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        req_be_n  = 2'b11;
        gpmc_ad_i = 16'h0000;
        gpmc_wait = 1'b0;
        t_addr    = 16'h0000;
        t_wdata   = 16'h0000;
        t_be      = 2'b11;
        t_wr      = 1'b0;
        t_oe_cnt  = 0;
        exp_rd_hold = 16'h0000;
        for (int i = 0; i < 64; i++) begin
            tgt_mem[i] = 16'($urandom);
            ref_mem[i] = tgt_mem[i];
        end
        tgt_mem[2] = 16'hCAFE;
        ref_mem[2] = 16'hCAFE;

        #1;
        check("rst_strobes", {gpmc_cs_n, gpmc_adv_n, gpmc_oe_n, gpmc_we_n, gpmc_ad_oe, gpmc_be_n},
              7'b1111011);
        check("rst_ad_o", gpmc_ad_o, 16'h0000);
        check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
        check("rst_rdata", rsp_rdata, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", req_ready, 1);

        // Directed: plain write, plain read, WAIT-stretched read, WAIT timeout.
        run_txn(1'b1, 16'h1234, 16'hBEEF, 2'b00, 0, 0, 1'b0);
        run_txn(1'b0, 16'h0042, 16'h0000, 2'b00, 0, 0, 1'b0);
        run_txn(1'b0, 16'h0042, 16'h0000, 2'b00, 4, 3, 1'b0);
        run_txn(1'b0, 16'h0034, 16'h0000, 2'b00, 0, 0, 1'b1);
        // Back-to-back write/readback, then a byte-lane write and readback.
        run_txn(1'b1, 16'h0007, 16'h1357, 2'b00, 0, 0, 1'b0);
        run_txn(1'b0, 16'h0007, 16'h0000, 2'b00, 0, 0, 1'b0);
        run_txn(1'b1, 16'h0007, 16'hAA55, 2'b10, 0, 0, 1'b0);
        run_txn(1'b0, 16'h0007, 16'h0000, 2'b00, 0, 0, 1'b0);
        check("readback_byte", exp_rd_hold, 16'h1355);

        // Reset in the middle of a write data phase.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0101;
        req_wdata = 16'h5A5A;
        req_be_n  = 2'b00;
        @(posedge clk);
        repeat (4) @(negedge clk);
        check("pre_rst_we", gpmc_we_n, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_async", {gpmc_cs_n, gpmc_we_n, gpmc_ad_oe}, 3'b110);
        check("rst_async_all", {gpmc_cs_n, gpmc_adv_n, gpmc_oe_n, gpmc_we_n, gpmc_ad_oe, gpmc_be_n},
              7'b1111011);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("rst_no_rsp", pulses, 0);
        check("rst_ready_after", req_ready, 1);
        check("rst_rdata_clr", rsp_rdata, 16'h0000);
        t_wr        = 1'b0;
        t_oe_cnt    = 0;
        exp_rd_hold = 16'h0000;

        // Random traffic, mostly back-to-back, with WAIT stalls and timeouts.
        for (int n = 0; n < 40; n++) begin
            wr    = 1'($urandom_range(0, 1));
            stuck = ($urandom_range(0, 9) == 0);
            s_at  = 0;
            s_len = 0;
            if ($urandom_range(0, 2) == 0) begin
                s_at  = $urandom_range(1, 10);
                s_len = $urandom_range(1, 6);
            end
            run_txn(wr, 16'($urandom), 16'($urandom), 2'($urandom), s_at, s_len, stuck);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                gap = $urandom_range(1, 3);
                repeat (gap) begin
                    target_step();
                    @(negedge clk);
                end
            end
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
